reg_writeback: RTL
==================

Name: reg_writeback

Overview:
- Write-side counterpart of the register-file read path.
- Accepts writeback requests from the datapath over a valid/ready handshake and selects the write data via vsel.
- Buffers up to 2 requests and commits them in order into an 8 x WIDTH register array.
- Exports all eight registers, flattened, plus per-register pending (busy) flags for the read-side selector and the controller.

Parameters:
- WIDTH, 16: register and data width.
- PCW, 8: program-counter width; zero-extended to WIDTH when selected.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- wb_valid  in  1  writeback request present.
- wb_ready  out  1  block can accept a request this cycle.
- writenum  in  3  destination register index.
- vsel  in  2  data source select: 00 C, 01 mdata, 10 sximm8, 11 pc.
- C  in  WIDTH  ALU result.
- mdata  in  WIDTH  memory read data.
- sximm8  in  WIDTH  sign-extended immediate.
- pc  in  PCW  program counter.
- stall  in  1  inhibits commits to the array this cycle.
- regs_out  out  8*WIDTH  reg0 in [WIDTH-1:0] … reg7 in top slice.
- busy  out  8  busy[n]=1 while any queued write targets reg n.
- wr_commit  out  1  one-cycle pulse, a write committed at the previous edge.
- commit_num  out  3  index of that committed write.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset (rst_n low, asynchronous):
  - all 8 registers = 0; queue emptied, count=0.
  - wr_commit=0, commit_num=0, busy=0.
  - wb_ready=1 (combinational from count).
- Accept: at an edge where wb_valid && wb_ready, push {writenum, data} at the queue tail.
  - data is muxed by vsel and sampled at acceptance, not at commit.
  - pc is zero-extended to WIDTH.
- wb_ready = (count < 2); purely combinational from count, independent of wb_valid and stall.
- Commit: at an edge where count > 0 && !stall:
  - regs[head.num] <= head.data; pop the head.
  - wr_commit <= 1; commit_num <= head.num.
  - Otherwise wr_commit <= 0 and commit_num holds.
- Latency: a request accepted at edge N commits at edge N+1 at the earliest, i.e. it is visible on regs_out in the cycle after N+1. No same-cycle write-through.
- Simultaneous accept and commit, count=1: count stays 1, order preserved.
- count=2: wb_ready=0, so no accept; a commit drops count to 1 and wb_ready rises next cycle.
- Stall held: queue fills to 2 and wb_ready=0; the array and regs_out are unchanged.
- Same-register writes: writes to the same index commit strictly in order, so the last accepted value wins.
- busy: combinational OR over valid queue entries of one-hot(num); clears in the cycle after that entry commits.
- Reset mid-operation: queued writes are discarded and never committed; no wr_commit pulse is produced.
- Invalid vsel is impossible (2-bit, fully decoded).

Optional Feature:
- Macro WB_BYPASS_EN.
- Defined: regs_out[n] shows the data of the youngest queued entry targeting n if one exists, otherwise the committed value. Forwarded view, zero added latency. busy still reports pending writes.
- Undefined: regs_out is the committed array only; no forwarding muxes.

Decomposition:
- Shared package:
  - WIDTH default, NREGS=8.
  - vsel encodings VSEL_C=2'b00, VSEL_MDATA=2'b01, VSEL_IMM=2'b10, VSEL_PC=2'b11.
  - writeback entry struct {num[2:0], data[WIDTH-1:0]}.
- One sub-module: wb_fifo2, a 2-entry in-order queue.
  - Ports: push, pop, count, head entry, both entries plus valid bits (used for busy and bypass).
- Register array and vsel mux stay in the top level.

Test Plan:
- Reset, then vsel=00, C=16'h1234, writenum=3, one-cycle valid, stall=0:
  - wr_commit pulses with commit_num=3; reg3 reads 16'h1234 in the cycle after the commit edge.
  - busy[3]=1 for exactly one cycle.
- stall=1, then accept writes r1<=mdata 16'hAAAA and r2<=sximm8 16'hFFF8:
  - wb_ready=0 after the second accept; a third valid is held and not accepted.
  - busy=8'b0000_0110.
  - Release stall: r1 then r2 commit on consecutive edges, then the third request is accepted.
- Back-to-back r5<=C 16'h0001 then r5<=C 16'h0002:
  - reg5 ends at 16'h0002; two wr_commit pulses, both with commit_num=5.
- vsel=11, pc=8'h9C, writenum=7: reg7 == 16'h009C.
- Two writes queued under stall, assert rst_n=0 asynchronously mid-clock:
  - immediate all regs 0, busy=0, wb_ready=1.
  - no wr_commit after release.
- WB_BYPASS_EN defined, stall=1, accept r4<=16'hBEEF:
  - reg4 slice of regs_out = 16'hBEEF in the cycle after acceptance, while the committed array still holds 0.
- WB_BYPASS_EN undefined, same stimulus: reg4 slice stays 0 until stall is released.

Source files
------------

// File: rtl/reg_writeback_pkg.sv
// reg_writeback_pkg: shared widths, vsel encodings and the writeback entry type.
package reg_writeback_pkg;
    localparam int DEFAULT_WIDTH = 16;
    localparam int NREGS = 8;
    localparam logic [1:0] VSEL_C = 2'b00;
    localparam logic [1:0] VSEL_MDATA = 2'b01;
    localparam logic [1:0] VSEL_IMM = 2'b10;
    localparam logic [1:0] VSEL_PC = 2'b11;
    typedef struct packed {
        logic [2:0] num;
        logic [DEFAULT_WIDTH-1:0] data;
    } wb_entry_t;
endpackage

// File: rtl/wb_fifo2.sv
// wb_fifo2: two-entry in-order queue; slot 0 always holds the head.
module wb_fifo2 import reg_writeback_pkg::*; #(
    parameter type T = wb_entry_t
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push_i,
    input  logic       pop_i,
    input  T           din_i,
    output logic [1:0] count_o,
    output T           head_o,
    output T           ent_o [2],
    output logic [1:0] vld_o
);
    T ent_q [2];
    T ent_d [2];
    logic [1:0] cnt_q, cnt_d;
    always_comb begin
        ent_d = ent_q;
        if (pop_i) ent_d[0] = ent_q[1];
        // pushing during a pop lands one slot lower than the current count
        if (push_i) ent_d[cnt_q[0] ^ pop_i] = din_i;
        cnt_d = cnt_q + 2'(push_i) - 2'(pop_i);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent_q <= '{default: '0};
            cnt_q <= '0;
        end else begin
            ent_q <= ent_d;
            cnt_q <= cnt_d;
        end
    end
    assign count_o = cnt_q;
    assign head_o = ent_q[0];
    assign ent_o = ent_q;
    assign vld_o = {cnt_q == 2'd2, cnt_q != 2'd0};
endmodule

// File: rtl/reg_writeback.sv
// reg_writeback: buffered in-order writeback into an 8-entry register array.
// Define WB_BYPASS_EN to forward queued data onto regs_out.
module reg_writeback import reg_writeback_pkg::*; #(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int PCW = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wb_valid,
    output logic               wb_ready,
    input  logic [2:0]         writenum,
    input  logic [1:0]         vsel,
    input  logic [WIDTH-1:0]   C,
    input  logic [WIDTH-1:0]   mdata,
    input  logic [WIDTH-1:0]   sximm8,
    input  logic [PCW-1:0]     pc,
    input  logic               stall,
    output logic [8*WIDTH-1:0] regs_out,
    output logic [7:0]         busy,
    output logic               wr_commit,
    output logic [2:0]         commit_num
);
    typedef struct packed {
        logic [2:0] num;
        logic [WIDTH-1:0] data;
    } entry_t;
    entry_t din, head;
    entry_t ent [2];
    logic [1:0] count, vld;
    logic push, pop;
    logic [WIDTH-1:0] regs_q [NREGS];
    logic wr_commit_q;
    logic [2:0] commit_num_q;
    assign wb_ready = count < 2'd2;
    assign push = wb_valid && wb_ready;
    assign pop = count != 2'd0 && !stall;
    assign din.num = writenum;
    assign din.data = vsel == VSEL_C ? C : vsel == VSEL_MDATA ? mdata :
                      vsel == VSEL_IMM ? sximm8 : WIDTH'(pc);
    wb_fifo2 #(.T(entry_t)) u_fifo (
        .clk(clk), .rst_n(rst_n), .push_i(push), .pop_i(pop), .din_i(din),
        .count_o(count), .head_o(head), .ent_o(ent), .vld_o(vld)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs_q <= '{default: '0};
            wr_commit_q <= 1'b0;
            commit_num_q <= '0;
        end else begin
            wr_commit_q <= pop;
            if (pop) begin
                regs_q[head.num] <= head.data;
                commit_num_q <= head.num;
            end
        end
    end
    assign wr_commit = wr_commit_q;
    assign commit_num = commit_num_q;
    always_comb begin
        busy = '0;
        for (int k = 0; k < 2; k++) if (vld[k]) busy[ent[k].num] = 1'b1;
    end
    for (genvar i = 0; i < NREGS; i++) begin : g_out
`ifdef WB_BYPASS_EN
        // slot 1 is younger than slot 0, so it wins when both target reg i
        assign regs_out[i*WIDTH +: WIDTH] =
            vld[1] && ent[1].num == 3'(i) ? ent[1].data :
            vld[0] && ent[0].num == 3'(i) ? ent[0].data : regs_q[i];
`else
        assign regs_out[i*WIDTH +: WIDTH] = regs_q[i];
`endif
    end
`ifndef WB_BYPASS_EN
    logic unused_data;
    assign unused_data = ^{ent[0].data, ent[1].data};
`endif
endmodule
